// File: rtl/alu_serial.sv
// Bit-serial ALU: WIDTH-bit op, SLICE bits per clock, LSB first.
// Optional signed set-less-than on control 3'h1 under ALU_SLT_EN.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy,
  output logic             done
);

  localparam int N   = WIDTH / SLICE;
  localparam int CWR = $clog2(N) + 1;
  localparam int CW  = (CWR < 4) ? 4 : CWR;

  typedef enum logic {IDLE, RUN} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_out;
  logic             r_co;
  logic             r_ov;
  logic             r_zero;
  logic             r_neg;
  logic             r_done;

  logic                   w_last;
  logic                   w_sub;
  logic                   w_arith;
  logic [SLICE-1:0]       w_a_sl;
  logic [SLICE-1:0]       w_b_sl;
  logic [SLICE-1:0]       w_b_eff;
  logic [SLICE:0]         w_sum;
  logic                   w_cin_msb;
  logic                   w_slt;
  logic [SLICE-1:0]       w_res_sl;
  logic [WIDTH+SLICE-1:0] w_cat;
  logic [WIDTH-1:0]       w_res_next;
  logic [WIDTH-1:0]       w_out_fin;
  logic                   w_co_fin;
  logic                   w_ov_fin;

  function automatic logic is_sub(input logic [2:0] c);
`ifdef ALU_SLT_EN
    return (c == 3'h3) || (c == 3'h1);
`else
    return (c == 3'h3);
`endif
  endfunction

  assign w_last  = (r_state == RUN) && (r_cnt == CW'(N - 1));
  assign w_sub   = is_sub(r_op);
  assign w_arith = (r_op == 3'h2) || (r_op == 3'h3);

  always_comb begin
    w_a_sl    = r_a[SLICE-1:0];
    w_b_sl    = r_b[SLICE-1:0];
    w_b_eff   = w_sub ? ~w_b_sl : w_b_sl;
    w_sum     = {1'b0, w_a_sl} + {1'b0, w_b_eff}
              + {{SLICE{1'b0}}, r_carry};
    w_cin_msb = w_a_sl[SLICE-1] ^ w_b_eff[SLICE-1]
              ^ w_sum[SLICE-1];
    w_slt     = w_sum[SLICE-1] ^ w_cin_msb ^ w_sum[SLICE];
    case (r_op)
      3'h2:    w_res_sl = w_sum[SLICE-1:0];
      3'h3:    w_res_sl = w_sum[SLICE-1:0];
      3'h4:    w_res_sl = w_a_sl & w_b_sl;
      3'h5:    w_res_sl = w_a_sl | w_b_sl;
      3'h6:    w_res_sl = ~(w_a_sl | w_b_sl);
      3'h7:    w_res_sl = w_a_sl ^ w_b_sl;
      default: w_res_sl = '0;
    endcase
    // Slices enter at the top so the LSB slice ends at bit 0
    w_cat      = {w_res_sl, r_res} >> SLICE;
    w_res_next = w_cat[WIDTH-1:0];
    w_out_fin  = w_res_next;
`ifdef ALU_SLT_EN
    if (r_op == 3'h1) w_out_fin = WIDTH'(w_slt);
`endif
    w_co_fin = w_arith & w_sum[SLICE];
    w_ov_fin = w_arith & (w_cin_msb ^ w_sum[SLICE]);
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_out   <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_a     <= A;
        r_b     <= B;
        r_op    <= control;
        r_carry <= is_sub(control);
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> SLICE;
        r_b     <= r_b >> SLICE;
        r_res   <= w_res_next;
        r_carry <= w_sum[SLICE];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_out  <= w_out_fin;
          r_co   <= w_co_fin;
          r_ov   <= w_ov_fin;
          r_zero <= (w_out_fin == '0);
          r_neg  <= w_out_fin[WIDTH-1];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign out      = r_out;
  assign carryout = r_co;
  assign overflow = r_ov;
  assign zero     = r_zero;
  assign negative = r_neg;
  assign busy     = (r_state == RUN);
  assign done     = r_done;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial at WIDTH=8, SLICE=2 (N=4).
// Table vectors, handshake corner sequences, random ops vs model.
module tb_alu_serial;

  localparam int W = 8;
  localparam int S = 2;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   control;
  logic [W-1:0] out;
  logic         carryout;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] c;
    logic [7:0] o;
    logic       co;
    logic       ov;
    logic       z;
    logic       n;
  } vec_t;

  vec_t tv[14];

  alu_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .A(A),
    .B(B),
    .control(control),
    .out(out),
    .carryout(carryout),
    .overflow(overflow),
    .zero(zero),
    .negative(negative),
    .busy(busy),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic [2:0] c);
    vec_t v;
    logic [8:0] s;
    v.a = a; v.b = b; v.c = c;
    v.o = 8'h00; v.co = 1'b0; v.ov = 1'b0;
    case (c)
      3'h2: begin
        s    = {1'b0, a} + {1'b0, b};
        v.o  = s[7:0];
        v.co = s[8];
        v.ov = (a[7] == b[7]) && (v.o[7] != a[7]);
      end
      3'h3: begin
        v.o  = a - b;
        v.co = (a >= b);
        v.ov = (a[7] != b[7]) && (v.o[7] != a[7]);
      end
      3'h4: v.o = a & b;
      3'h5: v.o = a | b;
      3'h6: v.o = ~(a | b);
      3'h7: v.o = a ^ b;
`ifdef ALU_SLT_EN
      3'h1: v.o = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
`endif
      default: v.o = 8'h00;
    endcase
    v.z = (v.o == 8'h00);
    v.n = v.o[7];
    return v;
  endfunction

  // Caller sits on a negedge; returns on the next one
  task automatic launch(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [2:0] c);
    A = a; B = b; control = c; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic chk_res(input string nm, input vec_t e);
    chk({nm, ".out"}, 32'(out), 32'(e.o));
    chk({nm, ".carryout"}, 32'(carryout), 32'(e.co));
    chk({nm, ".overflow"}, 32'(overflow), 32'(e.ov));
    chk({nm, ".zero"}, 32'(zero), 32'(e.z));
    chk({nm, ".negative"}, 32'(negative), 32'(e.n));
  endtask

  task automatic count_dones(input int cyc, output int nd);
    nd = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int nd;
    vec_t e;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [2:0] rc;

    checks = 0;
    errors = 0;
    reset = 1'b1; start = 1'b0;
    A = '0; B = '0; control = '0;

    tv[0]  = '{8'h7F, 8'h01, 3'h2, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{8'h05, 8'h05, 3'h3, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{8'h00, 8'h01, 3'h3, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{8'h0F, 8'hF0, 3'h4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{8'h0F, 8'hF0, 3'h5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{8'h0F, 8'hF0, 3'h6, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{8'h0F, 8'hF0, 3'h7, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{8'hFF, 8'h01, 3'h2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{8'h80, 8'h01, 3'h3, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{8'h12, 8'h34, 3'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{8'h55, 8'hAA, 3'h7, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ALU_SLT_EN
    tv[11] = '{8'hFD, 8'h02, 3'h1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    tv[11] = '{8'hFD, 8'h02, 3'h1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    tv[12] = '{8'h7F, 8'h80, 3'h1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[13] = '{8'h33, 8'h0D, 3'h2, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_res("rst", '{8'h00, 8'h00, 3'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 14; i++) begin
      launch(tv[i].a, tv[i].b, tv[i].c);
      wait_done(lat, bc);
      chk($sformatf("tv%0d.latency", i), 32'(lat), 32'd4);
      chk($sformatf("tv%0d.busycycles", i), 32'(bc), 32'd4);
      chk($sformatf("tv%0d.busy_at_done", i), 32'(busy), 32'd0);
      chk_res($sformatf("tv%0d", i), tv[i]);
      @(negedge clock);
      chk($sformatf("tv%0d.done_pulse", i), 32'(done), 32'd0);
    end

    // start while busy is ignored
    launch(8'h10, 8'h20, 3'h2);
    @(negedge clock);
    A = 8'hFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, bc);
    chk("ign.latency", 32'(lat), 32'd2);
    chk("ign.out", 32'(out), 32'h30);
    count_dones(8, nd);
    chk("ign.extra_done", 32'(nd), 32'd0);
    chk("ign.out_hold", 32'(out), 32'h30);

    // back-to-back start in the done cycle
    launch(8'h01, 8'h02, 3'h2);
    wait_done(lat, bc);
    chk("b2b.lat1", 32'(lat), 32'd4);
    launch(8'h05, 8'h06, 3'h2);
    chk("b2b.done_low", 32'(done), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.out_held", 32'(out), 32'h03);
    wait_done(lat, bc);
    chk("b2b.lat2", 32'(lat), 32'd4);
    chk("b2b.out", 32'(out), 32'h0B);

    // reset mid-run aborts without done
    @(negedge clock);
    launch(8'h01, 8'h01, 3'h2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk_res("abort", '{8'h00, 8'h00, 3'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    count_dones(8, nd);
    chk("abort.no_done", 32'(nd), 32'd0);
    launch(8'h03, 8'h04, 3'h2);
    wait_done(lat, bc);
    chk("abort.fresh_lat", 32'(lat), 32'd4);
    chk("abort.fresh_out", 32'(out), 32'h07);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 3'($urandom_range(0, 7));
      e  = model(ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      launch(ra, rb, rc);
      A = 8'($urandom);
      B = 8'($urandom);
      control = 3'($urandom);
      wait_done(lat, bc);
      chk($sformatf("rnd%0d.latency", i), 32'(lat), 32'd4);
      chk_res($sformatf("rnd%0d", i), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
